// File: rtl/rr_arbiter_5_32_pkg.sv
// Shared constants and state encoding for the 32-way round-robin arbiter.
package rr_arbiter_5_32_pkg;

    localparam int NUM_REQ = 32;
    localparam int IDX_W   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_5_32_if.sv
// Request/grant bundle between requesting agents and the arbiter.
interface rr_arbiter_5_32_if;
    import rr_arbiter_5_32_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               forced_rel;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  forced_rel
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output forced_rel
    );

endinterface

// File: rtl/rr_arbiter_5_32_decoder.sv
// 5-to-32 binary-to-one-hot decoder.
module decoder5_32
    import rr_arbiter_5_32_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_5_32.sv
// Round-robin arbiter: 32 requesters, registered index and one-hot grant,
// grant held until release or MAX_HOLD expiry, one bubble after every release.
module rr_arbiter_5_32
    import rr_arbiter_5_32_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    rr_arbiter_5_32_if.slave   bus
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) + 1 : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               frel_q, frel_d;
    logic [HC_W-1:0]    hold_q, hold_d;

    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [NUM_REQ-1:0] win_onehot;
    logic               hold_exp;

    // Rotating priority: the requester just after the last winner is highest.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && bus.req[last_q + IDX_W'(i)]) begin
                win_idx   = last_q + IDX_W'(i);
                win_found = 1'b1;
            end
        end
    end

    decoder5_32 u_dec (
        .idx    (win_idx),
        .onehot (win_onehot)
    );

    assign hold_exp = (MAX_HOLD != 0) &&
                      (hold_q == HC_W'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        grant_d = grant_q;
        valid_d = valid_q;
        frel_d  = 1'b0;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                    grant_d = win_onehot;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    idx_d   = '0;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (!bus.req[idx_q] || hold_exp) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    grant_d = '0;
                    valid_d = 1'b0;
                    frel_d  = bus.req[idx_q];
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '1;
            grant_q <= '0;
            valid_q <= 1'b0;
            frel_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            frel_q  <= frel_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.forced_rel  = frel_q;

endmodule

// File: tb/tb_rr_arbiter_5_32.sv
// Bench for rr_arbiter_5_32: owner-based reference model checked every cycle
// plus directed literal expectations.
module tb_rr_arbiter_5_32;

    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    rr_arbiter_5_32_if bus ();

    rr_arbiter_5_32 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: who owns the resource, how many cycles it has held it.
    int m_owner = -1;
    int m_last  = 31;
    int m_held  = 0;
    bit m_frel  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_last  = 31;
            m_held  = 0;
            m_frel  = 1'b0;
        end else if (m_owner < 0) begin
            m_frel = 1'b0;
            for (int i = 1; i <= 32; i++) begin
                if (m_owner < 0 && bus.req[(m_last + i) % 32])
                    m_owner = (m_last + i) % 32;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 1;
            end
        end else if (!bus.req[m_owner]) begin
            m_owner = -1;
            m_frel  = 1'b0;
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            m_owner = -1;
            m_frel  = 1'b1;
        end else begin
            m_held++;
            m_frel = 1'b0;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
            chk("m_idx", 32'(bus.grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            chk("m_grant", bus.grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_frel", 32'(bus.forced_rel), 32'(m_frel));
            chk("m_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(string nm, logic v, logic [4:0] idx, logic fr);
        chk({nm, "_valid"}, 32'(bus.grant_valid), 32'(v));
        chk({nm, "_idx"}, 32'(bus.grant_idx), 32'(idx));
        chk({nm, "_grant"}, bus.grant, v ? (32'd1 << idx) : 32'd0);
        chk({nm, "_frel"}, 32'(bus.forced_rel), 32'(fr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        do_reset();
        chk_en = 1'b1;
        lit("reset", 1'b0, 5'd0, 1'b0);

        // single requester 7
        bus.req = 32'h0000_0080;
        tick();
        chk("lit_grant80", bus.grant, 32'h0000_0080);
        lit("req7", 1'b1, 5'd7, 1'b0);
        bus.req = '0;
        tick();
        lit("rel7", 1'b0, 5'd0, 1'b0);
        tick();

        // full rotation with wrap
        do_reset();
        for (int k = 0; k <= 32; k++) begin
            bus.req = '1;
            tick();
            lit("rr", 1'b1, 5'(k % 32), 1'b0);
            bus.req = ~(32'd1 << (k % 32));
            tick();
            lit("rr_bub", 1'b0, 5'd0, 1'b0);
        end

        // wrap from last_idx=31
        do_reset();
        bus.req = 32'h8000_0001;
        tick();
        lit("wrap0", 1'b1, 5'd0, 1'b0);
        bus.req = 32'h8000_0000;
        tick();
        lit("wrap_bub", 1'b0, 5'd0, 1'b0);
        tick();
        lit("wrap31", 1'b1, 5'd31, 1'b0);
        bus.req = '0;
        tick();
        tick();

        // hold limit with single requester 5
        bus.req = 32'd1 << 5;
        tick();
        lit("hold_first", 1'b1, 5'd5, 1'b0);
        repeat (15) begin
            tick();
            chk("hold_kept", 32'(bus.grant_idx), 32'd5);
        end
        tick();
        lit("forced", 1'b0, 5'd0, 1'b1);
        tick();
        lit("regrant5", 1'b1, 5'd5, 1'b0);
        bus.req = (32'd1 << 5) | (32'd1 << 9);
        repeat (15) tick();
        lit("hold5_end", 1'b1, 5'd5, 1'b0);
        tick();
        lit("forced2", 1'b0, 5'd0, 1'b1);
        tick();
        lit("yield9", 1'b1, 5'd9, 1'b0);
        bus.req = '0;
        tick();
        tick();

        // reset mid-grant
        bus.req = 32'h0000_1000;
        tick();
        lit("g12", 1'b1, 5'd12, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        lit("mid_rst", 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        tick();
        lit("post_rst12", 1'b1, 5'd12, 1'b0);

        // release with another requester pending
        bus.req = 32'd1 << 3;
        tick();
        lit("rel_t1", 1'b0, 5'd0, 1'b0);
        tick();
        lit("rel_t2", 1'b1, 5'd3, 1'b0);
        bus.req = '0;
        tick();
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
